// File: rtl/dm_port_arbiter.sv
// Cycle-level arbiter sharing one single-port sync SRAM between the core and the loader.
// Optional perf counters (stall_cnt, ld_cnt) are enabled by defining DM_ARB_PERF_EN.
module dm_port_arbiter #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 32,
    parameter int MAX_STREAK = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              loading,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              mem_cen,
    output logic              mem_wen,
    output logic              mem_oen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_datain,
    input  logic [DATA_W-1:0] mem_dataout,
    output logic              busy
`ifdef DM_ARB_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       ld_cnt
`endif
);

    localparam int SW = $clog2(MAX_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

    typedef enum logic [1:0] {ST_RUN, ST_LOAD, ST_DRAIN} state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     streak_q, streak_d;
    logic              drain_cnt_q, drain_cnt_d;
    logic              loading_q;
    logic              mem_cen_q, mem_cen_d;
    logic              mem_wen_q, mem_wen_d;
    logic              mem_oen_q, mem_oen_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_datain_q, mem_datain_d;
    logic              rd_vld_q, rd_vld_d;
    logic              rd_own_q, rd_own_d;
    logic              core_rvalid_q, core_rvalid_d;
    logic              ld_rvalid_q, ld_rvalid_d;

    // Arbitration and mode FSM
    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        drain_cnt_d = drain_cnt_q;
        core_gnt    = 1'b0;
        ld_gnt      = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (loading) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = 1'b0;
                    streak_d    = '0;
                end else begin
                    if (ld_req && (streak_q == STREAK_MAX || !core_req))
                        ld_gnt = 1'b1;
                    else if (core_req)
                        core_gnt = 1'b1;
                    if (!ld_req || ld_gnt)
                        streak_d = '0;
                    else if (core_gnt && streak_q != STREAK_MAX)
                        streak_d = streak_q + SW'(1);
                end
            end
            ST_LOAD: begin
                streak_d = '0;
                if (!loading) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = 1'b0;
                end else begin
                    ld_gnt = ld_req;
                end
            end
            ST_DRAIN: begin
                streak_d = '0;
                // A loading edge or a read still in the SRAM restarts the quiet count
                if (loading != loading_q || rd_vld_q) begin
                    drain_cnt_d = 1'b0;
                end else if (drain_cnt_q) begin
                    state_d     = loading ? ST_LOAD : ST_RUN;
                    drain_cnt_d = 1'b0;
                end else begin
                    drain_cnt_d = 1'b1;
                end
            end
            default: begin
                state_d  = ST_RUN;
                streak_d = '0;
            end
        endcase
        if (rst) begin
            core_gnt = 1'b0;
            ld_gnt   = 1'b0;
        end
    end

    // Memory command and read owner tag
    always_comb begin
        mem_cen_d    = 1'b1;
        mem_wen_d    = 1'b1;
        mem_oen_d    = 1'b1;
        mem_addr_d   = mem_addr_q;
        mem_datain_d = mem_datain_q;
        rd_vld_d     = 1'b0;
        rd_own_d     = 1'b0;
        if (core_gnt) begin
            mem_cen_d  = 1'b0;
            mem_wen_d  = ~core_we;
            mem_oen_d  = core_we;
            mem_addr_d = core_addr;
            if (core_we) mem_datain_d = core_wdata;
            rd_vld_d   = ~core_we;
        end else if (ld_gnt) begin
            mem_cen_d  = 1'b0;
            mem_wen_d  = ~ld_we;
            mem_oen_d  = ld_we;
            mem_addr_d = ld_addr;
            if (ld_we) mem_datain_d = ld_wdata;
            rd_vld_d   = ~ld_we;
            rd_own_d   = 1'b1;
        end
        core_rvalid_d = rd_vld_q & ~rd_own_q;
        ld_rvalid_d   = rd_vld_q & rd_own_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            streak_q      <= '0;
            drain_cnt_q   <= 1'b0;
            loading_q     <= 1'b0;
            mem_cen_q     <= 1'b1;
            mem_wen_q     <= 1'b1;
            mem_oen_q     <= 1'b1;
            mem_addr_q    <= '0;
            mem_datain_q  <= '0;
            rd_vld_q      <= 1'b0;
            rd_own_q      <= 1'b0;
            core_rvalid_q <= 1'b0;
            ld_rvalid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            streak_q      <= streak_d;
            drain_cnt_q   <= drain_cnt_d;
            loading_q     <= loading;
            mem_cen_q     <= mem_cen_d;
            mem_wen_q     <= mem_wen_d;
            mem_oen_q     <= mem_oen_d;
            mem_addr_q    <= mem_addr_d;
            mem_datain_q  <= mem_datain_d;
            rd_vld_q      <= rd_vld_d;
            rd_own_q      <= rd_own_d;
            core_rvalid_q <= core_rvalid_d;
            ld_rvalid_q   <= ld_rvalid_d;
        end
    end

    assign mem_cen     = mem_cen_q;
    assign mem_wen     = mem_wen_q;
    assign mem_oen     = mem_oen_q;
    assign mem_addr    = mem_addr_q;
    assign mem_datain  = mem_datain_q;
    assign core_rvalid = core_rvalid_q;
    assign ld_rvalid   = ld_rvalid_q;
    // Read data is taken straight from the SRAM output register, steered by the owner tag
    assign core_rdata  = core_rvalid_q ? mem_dataout : '0;
    assign ld_rdata    = ld_rvalid_q ? mem_dataout : '0;
    assign busy        = (state_q == ST_DRAIN) | rd_vld_q;

`ifdef DM_ARB_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] ld_cnt_q, ld_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        ld_cnt_d    = ld_cnt_q;
        if (core_req && !core_gnt && stall_cnt_q != 32'hFFFF_FFFF)
            stall_cnt_d = stall_cnt_q + 32'd1;
        if (ld_gnt && ld_cnt_q != 32'hFFFF_FFFF)
            ld_cnt_d = ld_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            ld_cnt_q    <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            ld_cnt_q    <= ld_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign ld_cnt    = ld_cnt_q;
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Scoreboard bench for dm_port_arbiter: directed stimulus, SRAM model, decoupled read monitor.
module tb_dm_port_arbiter;
    localparam int AW = 11;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          loading = 1'b0;
    logic          core_req = 1'b0, core_we = 1'b0;
    logic [AW-1:0] core_addr = '0;
    logic [DW-1:0] core_wdata = '0;
    logic          core_gnt, core_rvalid;
    logic [DW-1:0] core_rdata;
    logic          ld_req = 1'b0, ld_we = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_wdata = '0;
    logic          ld_gnt, ld_rvalid;
    logic [DW-1:0] ld_rdata;
    logic          mem_cen, mem_wen, mem_oen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_datain;
    logic [DW-1:0] mem_dataout;
    logic          busy;
`ifdef DM_ARB_PERF_EN
    logic [31:0]   stall_cnt, ld_cnt;
`endif

    dm_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_STREAK(16)) dut (
        .clk(clk), .rst(rst), .loading(loading),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_oen(mem_oen),
        .mem_addr(mem_addr), .mem_datain(mem_datain), .mem_dataout(mem_dataout),
        .busy(busy)
`ifdef DM_ARB_PERF_EN
        , .stall_cnt(stall_cnt), .ld_cnt(ld_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Single-port sync SRAM, read data appears the cycle after the access
    logic [DW-1:0] sram [0:2047];
    always @(posedge clk) begin
        if (mem_cen === 1'b0) begin
            if (mem_wen === 1'b0) sram[mem_addr] <= mem_datain;
            else mem_dataout <= sram[mem_addr];
        end
    end

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t core_q[$];
    exp_t ld_q[$];
    int   checks = 0;
    int   errors = 0;
    int   core_gnt_in_load = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Read-return monitor
    always @(negedge clk) begin
        exp_t e;
        if (core_rvalid === 1'b1) begin
            if (core_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL core_rvalid_unexpected: got rvalid=1 data %0h expected none (cycle %0d)",
                         core_rdata, cyc);
            end else begin
                e = core_q.pop_front();
                chk("core_rdata", 64'(core_rdata), 64'(e.data));
                chk("core_rvalid_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
        if (ld_rvalid === 1'b1) begin
            if (ld_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL ld_rvalid_unexpected: got rvalid=1 data %0h expected none (cycle %0d)",
                         ld_rdata, cyc);
            end else begin
                e = ld_q.pop_front();
                chk("ld_rdata", 64'(ld_rdata), 64'(e.data));
                chk("ld_rvalid_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
        if (loading === 1'b1 && core_gnt === 1'b1) core_gnt_in_load++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns at the negedge of the grant cycle (or after the budget expires)
    task automatic wait_core_gnt(input string name);
        int n = 0;
        @(negedge clk);
        while (core_gnt !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(core_gnt), 64'd1);
    endtask

    task automatic core_acc(input logic we, input int addr, input logic [DW-1:0] wdata,
                            input logic [DW-1:0] exp_d, input bit push);
        step();
        core_req   = 1'b1;
        core_we    = we;
        core_addr  = AW'(addr);
        core_wdata = wdata;
        wait_core_gnt("core_gnt");
        if (core_gnt === 1'b1 && !we && push) core_q.push_back('{exp_d, cyc + 2});
    endtask

    initial begin
        int t0;
        int n;
        bit exp_ld;

        // Reset with random request activity
        repeat (2) begin
            step();
            core_req = 1'($urandom_range(0, 1));
            core_we  = 1'($urandom_range(0, 1));
            ld_req   = 1'($urandom_range(0, 1));
            ld_we    = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("rst_core_gnt", 64'(core_gnt), 0);
            chk("rst_ld_gnt", 64'(ld_gnt), 0);
            chk("rst_mem_cen", 64'(mem_cen), 1);
            chk("rst_mem_wen", 64'(mem_wen), 1);
            chk("rst_mem_oen", 64'(mem_oen), 1);
            chk("rst_mem_addr", 64'(mem_addr), 0);
            chk("rst_core_rvalid", 64'(core_rvalid), 0);
            chk("rst_ld_rvalid", 64'(ld_rvalid), 0);
            chk("rst_busy", 64'(busy), 0);
        end

        // Preload addr 0..2047 with data=addr while the core keeps requesting
        step();
        rst = 1'b0;
        loading = 1'b1;
        core_req = 1'b1; core_we = 1'b0; core_addr = AW'(7);
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = '0; ld_wdata = '0;
        n = 0;
        @(negedge clk);
        while (ld_gnt !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("load_first_gnt", 64'(ld_gnt), 1);
        chk("load_first_gnt_latency", 64'(n), 3);
        for (int a = 0; a < 2048; a++) begin
            step();
            if (a < 2047) begin
                ld_addr  = AW'(a + 1);
                ld_wdata = DW'(a + 1);
            end else begin
                ld_req = 1'b0;
            end
            @(negedge clk);
            chk("load_mem_cen", 64'(mem_cen), 0);
            chk("load_mem_wen", 64'(mem_wen), 0);
            chk("load_mem_oen", 64'(mem_oen), 1);
            chk("load_mem_addr", 64'(mem_addr), 64'(a));
            chk("load_mem_datain", 64'(mem_datain), 64'(a));
            if (a < 2047) chk("load_ld_gnt", 64'(ld_gnt), 1);
        end
        step();
        loading = 1'b0;
        wait_core_gnt("post_load_core_gnt");
        if (core_gnt === 1'b1) core_q.push_back('{32'd7, cyc + 2});

        // Core read addr 5: command at T+1, data at T+2
        core_acc(1'b0, 5, '0, 32'd5, 1'b1);
        t0 = cyc;
        step();
        core_req = 1'b0;
        @(negedge clk);
        chk("rd_mem_cen", 64'(mem_cen), 0);
        chk("rd_mem_oen", 64'(mem_oen), 0);
        chk("rd_mem_wen", 64'(mem_wen), 1);
        chk("rd_mem_addr", 64'(mem_addr), 5);
        chk("rd_busy", 64'(busy), 1);
        chk("rd_cycle", 64'(cyc), 64'(t0 + 1));
        step();

        // Write then pipelined back-to-back reads
        core_acc(1'b1, 9, 32'hDEAD, '0, 1'b1);
        core_acc(1'b0, 9, '0, 32'hDEAD, 1'b1);
        core_acc(1'b0, 1, '0, 32'd1, 1'b1);
        core_acc(1'b0, 2, '0, 32'd2, 1'b1);
        core_acc(1'b0, 3, '0, 32'd3, 1'b1);
        step();
        core_req = 1'b0;
        repeat (3) step();

        // Starvation bound: 16 core grants then one loader grant
        core_req = 1'b1; core_we = 1'b0; core_addr = AW'(10);
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = AW'(20);
        for (int i = 0; i < 34; i++) begin
            @(negedge clk);
            exp_ld = (i % 17 == 16);
            chk("starve_core_gnt", 64'(core_gnt), 64'(!exp_ld));
            chk("starve_ld_gnt", 64'(ld_gnt), 64'(exp_ld));
            if (core_gnt === 1'b1) core_q.push_back('{32'd10, cyc + 2});
            if (ld_gnt === 1'b1) ld_q.push_back('{32'd20, cyc + 2});
            step();
        end
        core_req = 1'b0;
        ld_req = 1'b0;
        repeat (3) step();

        // Mode switch with a core read in flight
        core_acc(1'b0, 5, '0, 32'd5, 1'b1);
        t0 = cyc;
        step();
        core_req = 1'b0;
        loading = 1'b1;
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = AW'(3);
        n = 0;
        @(negedge clk);
        while (ld_gnt !== 1'b1 && n < 20) begin
            if (cyc == t0 + 2) chk("mode_busy_drain", 64'(busy), 1);
            @(negedge clk);
            n++;
        end
        chk("mode_ld_gnt", 64'(ld_gnt), 1);
        chk("mode_ld_gnt_not_early", 64'(cyc >= t0 + 4), 1);
        if (ld_gnt === 1'b1) ld_q.push_back('{32'd3, cyc + 2});
        step();
        ld_req = 1'b0;
        loading = 1'b0;
        repeat (6) step();

        // Reset while a read is in flight: its return is dropped
        core_acc(1'b0, 5, '0, '0, 1'b0);
        step();
        rst = 1'b1;
        core_req = 1'b0;
        step();
        @(negedge clk);
        chk("rstmid_mem_cen", 64'(mem_cen), 1);
        chk("rstmid_mem_wen", 64'(mem_wen), 1);
        chk("rstmid_mem_oen", 64'(mem_oen), 1);
        chk("rstmid_mem_addr", 64'(mem_addr), 0);
        chk("rstmid_mem_datain", 64'(mem_datain), 0);
        chk("rstmid_core_rvalid", 64'(core_rvalid), 0);
        chk("rstmid_core_rdata", 64'(core_rdata), 0);
        chk("rstmid_busy", 64'(busy), 0);
        step();
        rst = 1'b0;
        repeat (4) step();

        chk("core_q_drained", 64'(core_q.size()), 0);
        chk("ld_q_drained", 64'(ld_q.size()), 0);
        chk("core_gnt_in_load", 64'(core_gnt_in_load), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end
endmodule
